// File: rtl/ldpc_pkg.sv
// Shared constants and FSM encoding for the flooding LDPC decoder scheduler,
// datapath and bench.
package ldpc_pkg;

  localparam int unsigned LdpcN          = 204;
  localparam int unsigned LdpcM          = 102;
  localparam int unsigned LdpcLogN       = 8;
  localparam int unsigned LdpcLogM       = 7;
  localparam int unsigned LdpcMaxIter    = 30;
  localparam int unsigned LdpcLogMaxIter = 5;
  localparam int unsigned LdpcLat        = 2;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCn,
    StCnDrain,
    StEval,
    StVn,
    StVnDrain,
    StFin
  } sched_state_e;

endpackage

// File: rtl/ldpc_iter_scheduler_if.sv
// Scheduler <-> decoder datapath bundle: sweep strobes/indices, parity returns
// and decode status.
interface ldpc_iter_scheduler_if;
  import ldpc_pkg::*;

  logic                      start;
  logic                      ld_en;
  logic [LdpcLogN-1:0]       ld_idx;
  logic                      cn_en;
  logic [LdpcLogM-1:0]       cn_idx;
  logic                      vn_en;
  logic [LdpcLogN-1:0]       vn_idx;
  logic                      par_valid;
  logic                      par_err;
  logic                      busy;
  logic                      done;
  logic                      success;
  logic [LdpcLogMaxIter-1:0] iterations;
  // Saturating count of parity results that arrived outside a check sweep.
  logic [7:0]                proto_err_cnt;

  modport master (
    input  start, par_valid, par_err,
    output ld_en, ld_idx, cn_en, cn_idx, vn_en, vn_idx,
           busy, done, success, iterations, proto_err_cnt
  );

  modport slave (
    output start, par_valid, par_err,
    input  ld_en, ld_idx, cn_en, cn_idx, vn_en, vn_idx,
           busy, done, success, iterations, proto_err_cnt
  );

endinterface

// File: rtl/ldpc_sweep_counter.sv
// Count-to-N index generator: a start pulse yields Count consecutive enabled
// cycles with idx 0..Count-1; idx then holds its last value.
module ldpc_sweep_counter #(
  parameter int unsigned Count = 8,
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             en_o,
  output logic [Width-1:0] idx_o,
  output logic             last_o
);

  logic             en_q;
  logic [Width-1:0] idx_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q  <= 1'b0;
      idx_q <= '0;
    end else if (start_i) begin
      en_q  <= 1'b1;
      idx_q <= '0;
    end else if (en_q) begin
      if (last_o) begin
        en_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign en_o   = en_q;
  assign idx_o  = idx_q;
  assign last_o = en_q && (idx_q == Width'(Count - 1));

endmodule

// File: rtl/ldpc_iter_scheduler.sv
// Control FSM for the time-multiplexed flooding LDPC decoder: load, then
// alternate CN/VN sweeps until the syndrome is clean or MaxIter is reached.
module ldpc_iter_scheduler
  import ldpc_pkg::*;
#(
  parameter int unsigned N       = LdpcN,
  parameter int unsigned M       = LdpcM,
  parameter int unsigned MaxIter = LdpcMaxIter,
  parameter int unsigned Lat     = LdpcLat
) (
  input logic                   clk_i,
  input logic                   rst_i,
  ldpc_iter_scheduler_if.master bus_io
);

  localparam logic [2:0]                LatLast = 3'(Lat - 1);
  localparam logic [LdpcLogMaxIter-1:0] IterMax = LdpcLogMaxIter'(MaxIter);

  sched_state_e              state_q;
  logic                      busy_q, done_q, success_q, syn_err_q;
  logic [LdpcLogMaxIter-1:0] iter_q;
  logic [2:0]                lat_q;
  logic [7:0]                proto_q;

  logic                ld_start, cn_start, vn_start;
  logic                ld_en, cn_en, vn_en;
  logic                ld_last, cn_last, vn_last;
  logic [LdpcLogN-1:0] ld_idx, vn_idx;
  logic [LdpcLogM-1:0] cn_idx;
  logic                drain_last, in_window;

  always_comb begin
    drain_last = (lat_q == LatLast);
    ld_start   = (state_q == StIdle) && bus_io.start;
    cn_start   = ((state_q == StLoad) && ld_last) || ((state_q == StVnDrain) && drain_last);
    vn_start   = (state_q == StEval) && syn_err_q && (iter_q != IterMax);
    in_window  = (state_q == StCn) || (state_q == StCnDrain);
  end

  ldpc_sweep_counter #(.Count(N), .Width(LdpcLogN)) u_ld_sweep (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(ld_start),
    .en_o   (ld_en),
    .idx_o  (ld_idx),
    .last_o (ld_last)
  );

  ldpc_sweep_counter #(.Count(M), .Width(LdpcLogM)) u_cn_sweep (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(cn_start),
    .en_o   (cn_en),
    .idx_o  (cn_idx),
    .last_o (cn_last)
  );

  ldpc_sweep_counter #(.Count(N), .Width(LdpcLogN)) u_vn_sweep (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(vn_start),
    .en_o   (vn_en),
    .idx_o  (vn_idx),
    .last_o (vn_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      success_q <= 1'b0;
      syn_err_q <= 1'b0;
      iter_q    <= '0;
      lat_q     <= '0;
      proto_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            state_q   <= StLoad;
            busy_q    <= 1'b1;
            success_q <= 1'b0;
            syn_err_q <= 1'b0;
            iter_q    <= '0;
          end
        end
        StLoad: begin
          if (ld_last) begin
            state_q   <= StCn;
            syn_err_q <= 1'b0;
          end
        end
        StCn: begin
          if (cn_last) begin
            state_q <= StCnDrain;
            lat_q   <= '0;
          end
        end
        StCnDrain: begin
          if (drain_last) state_q <= StEval;
          else            lat_q   <= lat_q + 1'b1;
        end
        StEval: begin
          if (!syn_err_q || (iter_q == IterMax)) begin
            state_q   <= StFin;
            success_q <= !syn_err_q;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            state_q <= StVn;
          end
        end
        StVn: begin
          if (vn_last) begin
            state_q <= StVnDrain;
            lat_q   <= '0;
          end
        end
        StVnDrain: begin
          if (drain_last) begin
            state_q   <= StCn;
            syn_err_q <= 1'b0;
            if (iter_q != IterMax) iter_q <= iter_q + 1'b1;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        StFin: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      // Parity results only count while a check sweep can still be returning.
      if (bus_io.par_valid) begin
        if (in_window) begin
          if (bus_io.par_err) syn_err_q <= 1'b1;
        end else if (proto_q != 8'hFF) begin
          proto_q <= proto_q + 1'b1;
        end
      end
    end
  end

  assign bus_io.ld_en         = ld_en;
  assign bus_io.ld_idx        = ld_idx;
  assign bus_io.cn_en         = cn_en;
  assign bus_io.cn_idx        = cn_idx;
  assign bus_io.vn_en         = vn_en;
  assign bus_io.vn_idx        = vn_idx;
  assign bus_io.busy          = busy_q;
  assign bus_io.done          = done_q;
  assign bus_io.success       = success_q;
  assign bus_io.iterations    = iter_q;
  assign bus_io.proto_err_cnt = proto_q;

endmodule

// File: tb/tb_ldpc_iter_scheduler.sv
// Scoreboard bench: directed decodes push expected results, negedge monitors
// pop and compare on every done pulse.
module tb_ldpc_iter_scheduler;
  import ldpc_pkg::*;

  localparam int BenchLat = 2;

  typedef struct {
    logic                      success;
    logic [LdpcLogMaxIter-1:0] iters;
    int                        cycles;
    int                        vn_cnt;
    int                        ld_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ldpc_iter_scheduler_if bus ();
  ldpc_iter_scheduler_if b1 ();
  ldpc_iter_scheduler_if b7 ();

  ldpc_iter_scheduler #(.Lat(BenchLat)) dut (.clk_i(clk), .rst_i(rst), .bus_io(bus));
  ldpc_iter_scheduler #(.Lat(1)) u_lat1 (.clk_i(clk), .rst_i(rst), .bus_io(b1));
  ldpc_iter_scheduler #(.Lat(7)) u_lat7 (.clk_i(clk), .rst_i(rst), .bus_io(b7));

  assign b1.par_valid = 1'b0;
  assign b1.par_err   = 1'b0;
  assign b7.par_valid = 1'b0;
  assign b7.par_err   = 1'b0;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   exp1_q[$];
  int   exp7_q[$];
  int   mode   = 0;
  logic stray  = 1'b0;

  function automatic void check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endfunction

  // Datapath model: parity result returns BenchLat cycles after each cn_en.
  logic [7:0] v_hist = '0;
  logic [7:0] e_hist = '0;
  int         sweep  = 0;
  always @(negedge clk) begin
    if (bus.ld_en && bus.ld_idx == 0) sweep = -1;
    if (bus.cn_en && bus.cn_idx == 0) sweep++;
    v_hist = {v_hist[6:0], bus.cn_en};
    e_hist = {e_hist[6:0], bus.cn_en && ((mode == 2) ||
                                         (mode == 1 && sweep < 3 && bus.cn_idx == 5))};
    bus.par_valid = v_hist[BenchLat] | stray;
    bus.par_err   = e_hist[BenchLat];
  end

  // Main monitor: cycle count from the start cycle (=1), sweep counts, order checks.
  int   cyc = 0, vn_cnt = 0, ld_cnt = 0;
  logic seq_bad = 1'b0, busy_prev = 1'b0;
  logic ld_pe = 1'b0, cn_pe = 1'b0, vn_pe = 1'b0;
  int   ld_pi = 0, cn_pi = 0, vn_pi = 0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (bus.busy && !busy_prev) begin
      cyc = 2; vn_cnt = 0; ld_cnt = 0; seq_bad = 1'b0;
    end
    busy_prev = bus.busy;
    if (int'(bus.ld_en) + int'(bus.cn_en) + int'(bus.vn_en) > 1) seq_bad = 1'b1;
    if (int'(bus.iterations) > int'(LdpcMaxIter)) seq_bad = 1'b1;
    if (bus.ld_en) begin
      ld_cnt++;
      if (int'(bus.ld_idx) != (ld_pe ? ld_pi + 1 : 0)) seq_bad = 1'b1;
    end
    if (bus.cn_en && int'(bus.cn_idx) != (cn_pe ? cn_pi + 1 : 0)) seq_bad = 1'b1;
    if (bus.vn_en) begin
      vn_cnt++;
      if (int'(bus.vn_idx) != (vn_pe ? vn_pi + 1 : 0)) seq_bad = 1'b1;
    end
    ld_pe = bus.ld_en; ld_pi = int'(bus.ld_idx);
    cn_pe = bus.cn_en; cn_pi = int'(bus.cn_idx);
    vn_pe = bus.vn_en; vn_pi = int'(bus.vn_idx);
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", int'(bus.done), 0);
      end else begin
        e = exp_q.pop_front();
        check("success", int'(bus.success), int'(e.success));
        check("iterations", int'(bus.iterations), int'(e.iters));
        check("done_cycle", cyc, e.cycles);
        check("vn_strobes", vn_cnt, e.vn_cnt);
        check("ld_strobes", ld_cnt, e.ld_cnt);
        check("sweep_order", int'(seq_bad), 0);
        check("busy_at_done", int'(bus.busy), 0);
      end
    end
  end

  int   cyc1 = 0, cyc7 = 0;
  logic bp1 = 1'b0, bp7 = 1'b0;
  always @(negedge clk) begin
    cyc1++; cyc7++;
    if (b1.busy && !bp1) cyc1 = 2;
    if (b7.busy && !bp7) cyc7 = 2;
    bp1 = b1.busy; bp7 = b7.busy;
    if (b1.done) begin
      if (exp1_q.size() == 0) check("lat1_spurious_done", int'(b1.done), 0);
      else begin
        check("lat1_done_cycle", cyc1, exp1_q.pop_front());
        check("lat1_success", int'(b1.success), 1);
      end
    end
    if (b7.done) begin
      if (exp7_q.size() == 0) check("lat7_spurious_done", int'(b7.done), 0);
      else begin
        check("lat7_done_cycle", cyc7, exp7_q.pop_front());
        check("lat7_success", int'(b7.success), 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic all);
    bus.start = 1'b1;
    if (all) begin
      b1.start = 1'b1;
      b7.start = 1'b1;
    end
    tick();
    bus.start = 1'b0;
    b1.start  = 1'b0;
    b7.start  = 1'b0;
  endtask

  task automatic wait_empty(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() + exp1_q.size() + exp7_q.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, exp_q.size() + exp1_q.size() + exp7_q.size(), 0);
  endtask

  function automatic longint out_vec();
    return longint'({bus.ld_en, bus.ld_idx, bus.cn_en, bus.cn_idx, bus.vn_en, bus.vn_idx,
                     bus.busy, bus.done, bus.success, bus.iterations});
  endfunction

  initial begin
    int n;
    bus.start = 1'b0;
    b1.start  = 1'b0;
    b7.start  = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_outputs", out_vec(), 0);
    check("reset_proto_cnt", int'(bus.proto_err_cnt), 0);

    // Clean word; extra start pulses while busy must be ignored.
    mode = 0;
    exp_q.push_back('{1'b1, 5'd0, 311, 0, 204});
    exp1_q.push_back(310);
    exp7_q.push_back(316);
    pulse_start(1'b1);
    repeat (50) tick();
    pulse_start(1'b0);
    pulse_start(1'b0);
    repeat (100) tick();
    pulse_start(1'b0);
    wait_empty(2000, "clean_decode_timeout");
    repeat (5) tick();

    // Check 5 odd during sweeps 0..2, then clean.
    mode = 1;
    exp_q.push_back('{1'b1, 5'd3, 1244, 612, 204});
    pulse_start(1'b0);
    wait_empty(3000, "three_iter_timeout");
    repeat (20) tick();
    check("success_held", int'(bus.success), 1);
    check("iterations_held", int'(bus.iterations), 3);

    // Never converges: stops at MaxIter.
    mode = 2;
    exp_q.push_back('{1'b0, 5'd30, 9641, 6120, 204});
    pulse_start(1'b0);
    check("success_cleared", int'(bus.success), 0);
    check("iterations_cleared", int'(bus.iterations), 0);
    wait_empty(12000, "max_iter_timeout");
    repeat (5) tick();

    // Abort with reset in the middle of the first VN sweep.
    pulse_start(1'b0);
    n = 0;
    while (!(bus.vn_en && bus.vn_idx == 100) && n < 2000) begin
      tick();
      n++;
    end
    check("vn_idx_100_reached", int'(bus.vn_en && bus.vn_idx == 100), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_outputs", out_vec(), 0);
    repeat (3) tick();

    mode = 0;
    exp_q.push_back('{1'b1, 5'd0, 311, 0, 204});
    pulse_start(1'b0);
    wait_empty(2000, "post_abort_timeout");
    repeat (5) tick();

    // Stray parity result while idle.
    stray = 1'b1;
    tick();
    stray = 1'b0;
    tick();
    check("proto_err_cnt", int'(bus.proto_err_cnt), 1);
    check("stray_no_busy", int'(bus.busy), 0);

    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
